player_ctrl: RTL and testbench

Sequencing controller for the player character. It sits between the debounced keyboard inputs and the character-move and shot datapaths. It gates left/right movement requests, launches and times out the shot, and handles ball collisions through a hit-freeze / invulnerable-respawn / game-over state machine. It also owns the lives counter and the character blink/visibility flag consumed by the drawing logic.

---
 rtl/player_ctrl.sv | 144 ++++++++++++++
 tb/tb_player_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_ctrl.sv
// Player sequencing controller: movement gating, shot launch/timeout,
// and the hit / respawn / game-over flow with lives and blink control.
module player_ctrl #(
    parameter int unsigned LIVES_INIT        = 3,
    parameter int unsigned HIT_FREEZE_FRAMES = 60,
    parameter int unsigned INVULN_FRAMES     = 90,
    parameter int unsigned BLINK_PERIOD      = 8,
    parameter int unsigned SHOT_MAX_FRAMES   = 120
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       keyLeft,
    input  logic       keyRight,
    input  logic       keyFire,
    input  logic       ballHit,
    input  logic       shotDone,
    input  logic       levelStart,
    output logic       moveLeft,
    output logic       moveRight,
    output logic       shotStart,
    output logic       shotActive,
    output logic       respawnReq,
    output logic       charVisible,
    output logic [2:0] lives,
    output logic       gameOver
);

    typedef enum logic [2:0] {WAIT_START, PLAY, HIT, RESPAWN, GAME_OVER} state_t;

    localparam logic [7:0] HIT_LAST   = 8'(HIT_FREEZE_FRAMES - 1);
    localparam logic [7:0] INV_LAST   = 8'(INVULN_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);
    localparam logic [7:0] SHOT_LAST  = 8'(SHOT_MAX_FRAMES - 1);

    state_t     state, state_nxt;
    logic [7:0] frame_cnt, blink_cnt, shot_cnt;
    logic       fire_prev;

    logic       fire_edge, hit_done, inv_done, blink_tick, shot_tmo;
    logic       entering, active_now, active_nxt, launch;
    logic       move_left_nxt, move_right_nxt, shot_active_nxt, respawn_nxt;
    logic       visible_nxt, game_over_nxt;
    logic [2:0] lives_nxt;

    always_comb begin
        fire_edge  = keyFire & ~fire_prev;
        hit_done   = startOfFrame && (frame_cnt == HIT_LAST);
        inv_done   = startOfFrame && (frame_cnt == INV_LAST);
        blink_tick = startOfFrame && (blink_cnt == BLINK_LAST);
        shot_tmo   = startOfFrame && (shot_cnt == SHOT_LAST);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= WAIT_START;
        else         state <= state_nxt;
    end

    // levelStart restarts the level from any state and outranks everything else
    always_comb begin
        state_nxt = state;
        if (levelStart) begin
            state_nxt = PLAY;
        end else begin
            case (state)
                PLAY:    if (ballHit)  state_nxt = HIT;
                HIT:     if (hit_done) state_nxt = (lives == '0) ? GAME_OVER : RESPAWN;
                RESPAWN: if (inv_done) state_nxt = PLAY;
                default: ;
            endcase
        end
    end

    always_comb begin
        entering   = levelStart || (state_nxt != state);
        active_now = (state == PLAY) || (state == RESPAWN);
        active_nxt = (state_nxt == PLAY) || (state_nxt == RESPAWN);
        launch     = active_now && active_nxt && !levelStart && fire_edge
                     && !shotActive && !shotDone;

        move_left_nxt  = active_nxt & keyLeft & ~keyRight;
        move_right_nxt = active_nxt & keyRight & ~keyLeft;

        if (!active_now || !active_nxt || levelStart) shot_active_nxt = 1'b0;
        else if (launch)                              shot_active_nxt = 1'b1;
        else if (shotDone || shot_tmo)                shot_active_nxt = 1'b0;
        else                                          shot_active_nxt = shotActive;

        respawn_nxt = levelStart || ((state_nxt == RESPAWN) && (state != RESPAWN));

        if (levelStart && (state == GAME_OVER))
            lives_nxt = 3'(LIVES_INIT);
        else if (!levelStart && (state == PLAY) && ballHit && (lives != '0))
            lives_nxt = lives - 3'd1;
        else
            lives_nxt = lives;

        case (state_nxt)
            GAME_OVER: visible_nxt = 1'b0;
            RESPAWN:   visible_nxt = entering ? 1'b1 : (charVisible ^ blink_tick);
            default:   visible_nxt = 1'b1;
        endcase

        game_over_nxt = (state_nxt == GAME_OVER);
    end

    // fire_prev resets high so a key already held at reset release is not an edge
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            moveLeft    <= 1'b0;
            moveRight   <= 1'b0;
            shotStart   <= 1'b0;
            shotActive  <= 1'b0;
            respawnReq  <= 1'b0;
            charVisible <= 1'b1;
            lives       <= 3'(LIVES_INIT);
            gameOver    <= 1'b0;
            fire_prev   <= 1'b1;
            frame_cnt   <= '0;
            blink_cnt   <= '0;
            shot_cnt    <= '0;
        end else begin
            moveLeft    <= move_left_nxt;
            moveRight   <= move_right_nxt;
            shotStart   <= launch;
            shotActive  <= shot_active_nxt;
            respawnReq  <= respawn_nxt;
            charVisible <= visible_nxt;
            lives       <= lives_nxt;
            gameOver    <= game_over_nxt;
            fire_prev   <= keyFire;

            if (entering)          frame_cnt <= '0;
            else if (startOfFrame) frame_cnt <= frame_cnt + 8'd1;

            if (entering || blink_tick) blink_cnt <= '0;
            else if (startOfFrame)      blink_cnt <= blink_cnt + 8'd1;

            if (launch)                          shot_cnt <= '0;
            else if (shotActive && startOfFrame) shot_cnt <= shot_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with a per-cycle behavioural reference model.
module tb_player_ctrl;

    localparam int LIVES = 2;
    localparam int FREEZE = 3;
    localparam int INVULN = 4;
    localparam int BLINK = 2;
    localparam int SHOTMAX = 5;

    logic clk;
    logic resetN;
    logic startOfFrame, keyLeft, keyRight, keyFire, ballHit, shotDone, levelStart;
    logic moveLeft, moveRight, shotStart, shotActive, respawnReq, charVisible, gameOver;
    logic [2:0] lives;

    int total = 0;
    int bad = 0;

    player_ctrl #(
        .LIVES_INIT(LIVES),
        .HIT_FREEZE_FRAMES(FREEZE),
        .INVULN_FRAMES(INVULN),
        .BLINK_PERIOD(BLINK),
        .SHOT_MAX_FRAMES(SHOTMAX)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .keyLeft(keyLeft), .keyRight(keyRight), .keyFire(keyFire),
        .ballHit(ballHit), .shotDone(shotDone), .levelStart(levelStart),
        .moveLeft(moveLeft), .moveRight(moveRight), .shotStart(shotStart),
        .shotActive(shotActive), .respawnReq(respawnReq), .charVisible(charVisible),
        .lives(lives), .gameOver(gameOver)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode plus elapsed-frame and shot-age counts.
    typedef enum {M_WAIT, M_PLAY, M_HIT, M_RESPAWN, M_OVER} mode_t;
    mode_t m_mode = M_WAIT, m_was, m_new;
    int m_elapsed = 0;
    int m_age = 0;
    bit m_fire_prev = 1'b1;
    bit m_fe, m_restart, m_can;
    bit e_ml = 0, e_mr = 0, e_ss = 0, e_sa = 0, e_rr = 0, e_cv = 1, e_go = 0;
    int e_lives = LIVES;

    function automatic bit mobile(input mode_t m);
        return (m == M_PLAY) || (m == M_RESPAWN);
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_mode = M_WAIT; m_elapsed = 0; m_age = 0; m_fire_prev = 1'b1;
            e_ml = 0; e_mr = 0; e_ss = 0; e_sa = 0; e_rr = 0; e_cv = 1; e_go = 0;
            e_lives = LIVES;
        end else begin
            m_fe = keyFire && !m_fire_prev;
            m_fire_prev = keyFire;
            m_was = m_mode;
            m_new = m_was;
            m_restart = levelStart;
            e_ss = 0;
            e_rr = 0;
            if (m_restart) begin
                if (m_was == M_OVER) e_lives = LIVES;
                m_new = M_PLAY;
                e_rr = 1;
            end else if (m_was == M_PLAY && ballHit) begin
                if (e_lives > 0) e_lives = e_lives - 1;
                m_new = M_HIT;
            end else if (startOfFrame && m_was == M_HIT && m_elapsed + 1 == FREEZE) begin
                if (e_lives == 0) m_new = M_OVER;
                else begin
                    m_new = M_RESPAWN;
                    e_rr = 1;
                end
            end else if (startOfFrame && m_was == M_RESPAWN && m_elapsed + 1 == INVULN) begin
                m_new = M_PLAY;
            end
            if (m_restart || m_new != m_was) m_elapsed = 0;
            else if (startOfFrame) m_elapsed = m_elapsed + 1;
            m_mode = m_new;

            m_can = mobile(m_was) && mobile(m_new) && !m_restart;
            if (!m_can) e_sa = 0;
            else if (e_sa) begin
                if (shotDone) e_sa = 0;
                else if (startOfFrame) begin
                    m_age = m_age + 1;
                    if (m_age == SHOTMAX) e_sa = 0;
                end
            end else if (m_fe && !shotDone) begin
                e_sa = 1;
                e_ss = 1;
                m_age = 0;
            end

            e_ml = mobile(m_new) && keyLeft && !keyRight;
            e_mr = mobile(m_new) && keyRight && !keyLeft;
            if (m_new == M_OVER) e_cv = 0;
            else if (m_new == M_RESPAWN) e_cv = ((m_elapsed / BLINK) % 2) == 0;
            else e_cv = 1;
            e_go = (m_new == M_OVER);
        end
    end

    always @(negedge clk) begin
        check("moveLeft", 8'(moveLeft), 8'(e_ml));
        check("moveRight", 8'(moveRight), 8'(e_mr));
        check("shotStart", 8'(shotStart), 8'(e_ss));
        check("shotActive", 8'(shotActive), 8'(e_sa));
        check("respawnReq", 8'(respawnReq), 8'(e_rr));
        check("charVisible", 8'(charVisible), 8'(e_cv));
        check("lives", 8'(lives), 8'(e_lives));
        check("gameOver", 8'(gameOver), 8'(e_go));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0;
        startOfFrame = 0; keyLeft = 0; keyRight = 0; keyFire = 0;
        ballHit = 0; shotDone = 0; levelStart = 0;
        repeat (3) tick();
        check("rst_lives", 8'(lives), 8'd2);
        check("rst_vis", 8'(charVisible), 8'd1);
        check("rst_go", 8'(gameOver), 8'd0);
        check("rst_sa", 8'(shotActive), 8'd0);
        resetN = 1'b1;
        tick(); tick();

        // level start and movement gating
        levelStart = 1; tick();
        check("ls_rr", 8'(respawnReq), 8'd1);
        levelStart = 0; keyRight = 1; tick();
        check("rr_one", 8'(respawnReq), 8'd0);
        check("mr_on", 8'(moveRight), 8'd1);
        keyLeft = 1; tick();
        check("both_mr", 8'(moveRight), 8'd0);
        check("both_ml", 8'(moveLeft), 8'd0);
        keyLeft = 0; keyRight = 0; tick();

        // shot launch, discard, timeout, shotDone
        keyFire = 1; tick();
        check("ss_pulse", 8'(shotStart), 8'd1);
        check("sa_set", 8'(shotActive), 8'd1);
        tick();
        check("ss_once", 8'(shotStart), 8'd0);
        keyFire = 0; tick(); keyFire = 1; tick();
        check("ss_discard", 8'(shotStart), 8'd0);
        keyFire = 0;
        repeat (4) frame();
        check("sa_4fr", 8'(shotActive), 8'd1);
        frame();
        check("sa_5fr", 8'(shotActive), 8'd0);
        keyFire = 1; tick();
        check("sa_relaunch", 8'(shotActive), 8'd1);
        keyFire = 0; shotDone = 1; tick();
        check("sa_done", 8'(shotActive), 8'd0);
        shotDone = 0; tick();
        keyFire = 1; shotDone = 1; tick();
        check("fire_done_ss", 8'(shotStart), 8'd0);
        check("fire_done_sa", 8'(shotActive), 8'd0);
        keyFire = 0; shotDone = 0; tick();

        // first hit, freeze, invulnerable respawn
        keyFire = 1; tick(); keyFire = 0;
        keyRight = 1; tick();
        check("pre_hit_mr", 8'(moveRight), 8'd1);
        ballHit = 1; tick(); ballHit = 0;
        check("hit_lives", 8'(lives), 8'd1);
        check("hit_sa", 8'(shotActive), 8'd0);
        check("hit_mr", 8'(moveRight), 8'd0);
        frame(); frame();
        check("freeze_rr", 8'(respawnReq), 8'd0);
        startOfFrame = 1; tick();
        check("resp_rr", 8'(respawnReq), 8'd1);
        startOfFrame = 0; tick();
        check("resp_vis0", 8'(charVisible), 8'd1);
        check("resp_mr", 8'(moveRight), 8'd1);
        ballHit = 1;
        frame(); check("resp_vis1", 8'(charVisible), 8'd1);
        frame(); check("resp_vis2", 8'(charVisible), 8'd0);
        check("resp_nohit", 8'(lives), 8'd1);
        ballHit = 0;
        frame(); check("resp_vis3", 8'(charVisible), 8'd0);
        frame(); check("play_vis", 8'(charVisible), 8'd1);
        check("play_lives", 8'(lives), 8'd1);
        keyRight = 0; tick();

        // second hit to game over, then restart
        ballHit = 1; tick(); ballHit = 0;
        check("hit2_lives", 8'(lives), 8'd0);
        repeat (3) frame();
        check("go_flag", 8'(gameOver), 8'd1);
        check("go_vis", 8'(charVisible), 8'd0);
        levelStart = 1; tick(); levelStart = 0;
        check("restart_lives", 8'(lives), 8'd2);
        check("restart_rr", 8'(respawnReq), 8'd1);
        check("restart_go", 8'(gameOver), 8'd0);
        tick();

        // levelStart beats ballHit
        levelStart = 1; ballHit = 1; tick();
        levelStart = 0; ballHit = 0;
        check("prio_lives", 8'(lives), 8'd2);
        check("prio_rr", 8'(respawnReq), 8'd1);
        tick();

        // asynchronous reset in HIT, fire held through release
        ballHit = 1; tick(); ballHit = 0;
        check("hit3_lives", 8'(lives), 8'd1);
        keyFire = 1;
        frame();
        resetN = 0; #1;
        check("async_lives", 8'(lives), 8'd2);
        check("async_vis", 8'(charVisible), 8'd1);
        check("async_rr", 8'(respawnReq), 8'd0);
        tick(); tick();
        resetN = 1; tick();
        levelStart = 1; tick(); levelStart = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_fire", 8'(shotStart), 8'd0);
        end
        keyFire = 0; tick(); keyFire = 1; tick();
        check("fresh_fire", 8'(shotStart), 8'd1);
        keyFire = 0; tick();
        check("fresh_once", 8'(shotStart), 8'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
